mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester controller in front of the single-port word memory.
- Arbitrates between the instruction-fetch port (I, read-only) and the load/store port (D, read/write).
- Sequences each access as a one-cycle issue followed by a one-cycle response, so the memory never sees simultaneous read and write enables.
- Returns read data and the memory's 2-bit status code (`memory_states.vh`) to the winning requester.

Parameters:
- RR_ENABLE, 1, 1 = round-robin on ties; 0 = fixed priority, D always wins ties.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- clk_enable  in  1  core run enable; 0 freezes the arbiter, and it is forwarded to the memory
- i_req_valid  in  1  I request pending
- i_req_addr  in  32  I byte address
- i_req_ready  out  1  I request accepted this cycle
- i_rsp_valid  out  1  I response pulse
- i_rsp_data  out  32  I read data
- i_rsp_err  out  2  I status code
- d_req_valid  in  1  D request pending
- d_req_we  in  1  1 = write, 0 = read
- d_req_addr  in  32  D byte address
- d_req_wdata  in  32  D write data
- d_req_wstrb  in  4  D byte strobes
- d_req_ready  out  1  D request accepted
- d_rsp_valid  out  1  D response pulse, for reads and writes
- d_rsp_data  out  32  D read data; 0 for writes
- d_rsp_err  out  2  D status code
- m_clk_enable  out  1  equals clk_enable
- m_r_en  out  1  memory read enable
- m_r_addr  out  32  memory read address
- m_r_data  in  32  memory read data, valid the cycle after m_r_en
- m_w_en  out  1  memory write enable
- m_w_addr  out  32  memory write address
- m_w_data  out  32  memory write data
- m_w_strb  out  4  memory write strobes
- m_state  in  2  memory status, valid the cycle after an enable

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Reset: state = IDLE, last_grant = I, latched request cleared.
- Reset output values: all ready, rsp_valid, m_r_en and m_w_en = 0; all data and address outputs = 0.
- Accept condition: ready is asserted only in IDLE or RESP, only with clk_enable = 1, and only to the arbitration winner. At most one ready is high per cycle.
- Arbitration:
  - Single valid requester: it wins.
  - Both valid with RR_ENABLE = 1: the requester other than last_grant wins.
  - Both valid with RR_ENABLE = 0: D wins.
  - last_grant updates on every accept.
- Accept (valid && ready at a rising edge): latch addr/we/wdata/wstrb and the grant owner, then go to ISSUE.
- ISSUE (exactly one cycle):
  - Read: drive m_r_en = 1 with the latched address.
  - D write: drive m_w_en = 1 with the latched address, data and strobes.
  - m_r_en and m_w_en are never both 1.
  - Next state is RESP.
- RESP (exactly one cycle):
  - Owner's rsp_valid = 1.
  - rsp_err = m_state.
  - rsp_data = m_r_data for a successful read; 0 for writes and for any non-SUCCESS status.
  - Response cannot be back-pressured.
  - Next state: ISSUE if a new accept occurs in this cycle, else IDLE.
- Latency and throughput: response arrives 2 cycles after the accept edge. Back-to-back throughput is one access per 2 cycles.
- Memory enables are registered-free decodes of the FSM state and latched request. The non-owner's rsp_valid stays 0.
- Error pass-through: out-of-bounds and misaligned addresses are not pre-checked. The memory's status is returned unmodified. A failed write has no side effect beyond what the memory does.
- clk_enable = 0:
  - FSM, latches and last_grant hold.
  - ready, rsp_valid, m_r_en and m_w_en are forced to 0.
  - The pending ISSUE/RESP resumes when clk_enable returns to 1.
  - A response is delivered exactly once.
- Reset mid-operation: return to IDLE and discard the outstanding transaction; no rsp_valid is produced.
- Requester contract: addr/data must stay stable while valid && !ready.

Test Plan:
- Single I read of addr 0x10 (mem word 4 = 0xDEADBEEF) → i_req_ready at T, m_r_en at T+1, i_rsp_valid at T+2 with data 0xDEADBEEF and err SUCCESS.
- D write 0x11223344 with strobe 4'b0101 to 0x20, then D read of 0x20 (word previously 0xAABBCCDD) → read returns 0xAA22CC44; m_w_en and m_r_en never overlap.
- I and D both valid continuously, RR_ENABLE = 1 → grants D, I, D, I…, each response 2 cycles after its accept.
- D read of 0x2 → d_rsp_err = ALIGNMENT, d_rsp_data = 0. Read of 4·MEMORY_SIZE_WORDS → OUT_OF_BOUNDS.
- Drop clk_enable during ISSUE for 5 cycles → no enables or responses while low; exactly one response after resume with correct data.
- Assert rst_n = 0 during RESP → rsp_valid = 0 next cycle, FSM in IDLE, last_grant = I, no duplicate response after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: I/D request arbiter in front of a single-port word memory.
// Each access is a one-cycle issue followed by a one-cycle response.
module mem_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_enable,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        i_req_ready,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  output logic [1:0]  i_rsp_err,
  input  logic        d_req_valid,
  input  logic        d_req_we,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_wstrb,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic [1:0]  d_rsp_err,
  output logic        m_clk_enable,
  output logic        m_r_en,
  output logic [31:0] m_r_addr,
  input  logic [31:0] m_r_data,
  output logic        m_w_en,
  output logic [31:0] m_w_addr,
  output logic [31:0] m_w_data,
  output logic [3:0]  m_w_strb,
  input  logic [1:0]  m_state
);

  localparam logic [1:0] ST_SUCCESS = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_d_q, last_d_d;
  logic        own_d_q, own_d_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic        run;
  logic        can_acc;
  logic        pick_d;
  logic        acc;
  logic        issue;
  logic        resp;
  logic        rd_ok;
  logic [31:0] rdata;

  // Both clk_enable and reset silence every handshake and enable at once.
  assign run     = clk_enable & rst_n;
  assign can_acc = run & (state_q == IDLE || state_q == RESP);

  // D wins alone, on fixed-priority ties, or when I was granted last.
  assign pick_d = d_req_valid &
                  (~i_req_valid | ~RR_ENABLE | ~last_d_q);

  assign i_req_ready = can_acc & i_req_valid & ~pick_d;
  assign d_req_ready = can_acc & pick_d;
  assign acc         = i_req_ready | d_req_ready;

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    own_d_d  = own_d_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    if (clk_enable) begin
      unique case (state_q)
        IDLE:    if (acc) state_d = ISSUE;
        ISSUE:   state_d = RESP;
        RESP:    state_d = acc ? ISSUE : IDLE;
        default: state_d = IDLE;
      endcase
    end
    if (acc) begin
      last_d_d = pick_d;
      own_d_d  = pick_d;
      we_d     = pick_d & d_req_we;
      addr_d   = pick_d ? d_req_addr : i_req_addr;
      wdata_d  = pick_d ? d_req_wdata : '0;
      wstrb_d  = pick_d ? d_req_wstrb : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      own_d_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      own_d_q  <= own_d_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

  assign issue = run & (state_q == ISSUE);
  assign resp  = run & (state_q == RESP);

  assign m_clk_enable = clk_enable;
  assign m_r_en       = issue & ~we_q;
  assign m_w_en       = issue & we_q;
  assign m_r_addr     = addr_q;
  assign m_w_addr     = addr_q;
  assign m_w_data     = wdata_q;
  assign m_w_strb     = wstrb_q;

  // Only a successful read carries data back; writes and faults return 0.
  assign rd_ok = ~we_q & (m_state == ST_SUCCESS);
  assign rdata = rd_ok ? m_r_data : '0;

  assign i_rsp_valid = resp & ~own_d_q;
  assign d_rsp_valid = resp & own_d_q;
  assign i_rsp_data  = i_rsp_valid ? rdata : '0;
  assign d_rsp_data  = d_rsp_valid ? rdata : '0;
  assign i_rsp_err   = i_rsp_valid ? m_state : '0;
  assign d_rsp_err   = d_rsp_valid ? m_state : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter
// against a word memory model and a transaction-level scoreboard.
module tb_mem_arbiter;

  localparam int MEMW = 64;
  localparam logic [1:0] SUCCESS = 2'd0;
  localparam logic [1:0] OOB     = 2'd1;
  localparam logic [1:0] ALIGN   = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_enable = 1'b1;
  logic        i_req_valid = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic        i_req_ready;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic [1:0]  i_rsp_err;
  logic        d_req_valid = 1'b0;
  logic        d_req_we = 1'b0;
  logic [31:0] d_req_addr = '0;
  logic [31:0] d_req_wdata = '0;
  logic [3:0]  d_req_wstrb = '0;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic [1:0]  d_rsp_err;
  logic        m_clk_enable;
  logic        m_r_en;
  logic [31:0] m_r_addr;
  logic [31:0] m_r_data;
  logic        m_w_en;
  logic [31:0] m_w_addr;
  logic [31:0] m_w_data;
  logic [3:0]  m_w_strb;
  logic [1:0]  m_state;

  int n_checks = 0;
  int n_pass = 0;
  int overlap_cnt = 0;
  int i_rsp_cnt = 0;
  int d_rsp_cnt = 0;

  logic [31:0] mem [MEMW];
  logic [31:0] gold [MEMW];

  mem_arbiter #(.RR_ENABLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .i_req_ready(i_req_ready), .i_rsp_valid(i_rsp_valid),
    .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .d_rsp_err(d_rsp_err), .m_clk_enable(m_clk_enable),
    .m_r_en(m_r_en), .m_r_addr(m_r_addr), .m_r_data(m_r_data),
    .m_w_en(m_w_en), .m_w_addr(m_w_addr), .m_w_data(m_w_data),
    .m_w_strb(m_w_strb), .m_state(m_state)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] status_of(input logic [31:0] a);
    if (a[1:0] != 2'b00) return ALIGN;
    if (a >= 32'(4 * MEMW)) return OOB;
    return SUCCESS;
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, MEMW + 7)) * 4;
    if ($urandom % 8 == 0) a = a + 32'($urandom % 4);
    return a;
  endfunction

  // Single-port word memory: data and status valid the cycle after an enable.
  initial begin
    logic [1:0]  st;
    logic [31:0] w;
    for (int k = 0; k < MEMW; k++) mem[k] = $urandom;
    mem[4] = 32'hDEADBEEF;
    mem[5] = 32'h5555AAAA;
    mem[8] = 32'hAABBCCDD;
    m_r_data = '0;
    m_state = SUCCESS;
    forever begin
      @(posedge clk);
      if (m_clk_enable) begin
        if (m_r_en) begin
          st = status_of(m_r_addr);
          m_state <= st;
          m_r_data <= (st == SUCCESS) ? mem[m_r_addr[7:2]] : 32'hBAD0BAD0;
        end
        if (m_w_en) begin
          st = status_of(m_w_addr);
          m_state <= st;
          if (st == SUCCESS) begin
            w = mem[m_w_addr[7:2]];
            for (int b = 0; b < 4; b++)
              if (m_w_strb[b]) w[8*b +: 8] = m_w_data[8*b +: 8];
            mem[m_w_addr[7:2]] <= w;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_r_en && m_w_en) overlap_cnt++;
    if (i_rsp_valid) i_rsp_cnt++;
    if (d_rsp_valid) d_rsp_cnt++;
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    clk_enable = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic d_xact(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic [1:0] er,
                        output int lat);
    int n;
    lat = -1;
    rd = 'x;
    er = 'x;
    @(posedge clk); #1;
    d_req_valid = 1'b1;
    d_req_we = we;
    d_req_addr = a;
    d_req_wdata = wd;
    d_req_wstrb = st;
    n = 0;
    @(negedge clk);
    while (!d_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!d_req_ready) begin
      d_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1 d_req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (d_rsp_valid) begin
        rd = d_rsp_data;
        er = d_rsp_err;
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk_enable = 1'b1;
    i_req_valid = 1'b1;
    i_req_addr = 32'h10;
    d_req_valid = 1'b1;
    d_req_addr = 32'h20;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({i_req_ready, d_req_ready} !== 2'b00)
      $display("FAIL rst_ready got %b want 00", {i_req_ready, d_req_ready});
    else n_pass++;
    n_checks++;
    if ({i_rsp_valid, d_rsp_valid, m_r_en, m_w_en} !== 4'b0000)
      $display("FAIL rst_valids got %b want 0000",
               {i_rsp_valid, d_rsp_valid, m_r_en, m_w_en});
    else n_pass++;
    n_checks++;
    if ({m_r_addr, m_w_addr, m_w_data, m_w_strb} !== '0)
      $display("FAIL rst_mem_bus got %h/%h/%h/%h want 0",
               m_r_addr, m_w_addr, m_w_data, m_w_strb);
    else n_pass++;
    n_checks++;
    if ({i_rsp_data, d_rsp_data, i_rsp_err, d_rsp_err} !== '0)
      $display("FAIL rst_rsp_data got %h %h want 0", i_rsp_data, d_rsp_data);
    else n_pass++;
    n_checks++;
    if (m_clk_enable !== clk_enable)
      $display("FAIL rst_m_clk_enable got %b want %b", m_clk_enable, clk_enable);
    else n_pass++;
    #1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    @(posedge clk); #1;
    i_req_valid = 1'b1;
    i_req_addr = 32'h10;
    @(negedge clk);
    n_checks++;
    if ({i_req_ready, d_req_ready} !== 2'b10)
      $display("FAIL sr_ready got %b want 10", {i_req_ready, d_req_ready});
    else n_pass++;
    @(posedge clk); #1 i_req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m_r_en, m_w_en, i_req_ready} !== 3'b100 || m_r_addr !== 32'h10)
      $display("FAIL sr_issue got en=%b%b rdy=%b addr=%h want 10 0 00000010",
               m_r_en, m_w_en, i_req_ready, m_r_addr);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({i_rsp_valid, d_rsp_valid} !== 2'b10)
      $display("FAIL sr_rsp_valid got %b want 10", {i_rsp_valid, d_rsp_valid});
    else n_pass++;
    n_checks++;
    if (i_rsp_data !== 32'hDEADBEEF || i_rsp_err !== SUCCESS)
      $display("FAIL sr_rsp_data got %h/%0d want deadbeef/%0d",
               i_rsp_data, i_rsp_err, SUCCESS);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (i_rsp_valid !== 1'b0)
      $display("FAIL sr_rsp_once got %b want 0", i_rsp_valid);
    else n_pass++;
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic [1:0]  er;
    int lat, ov0;
    ov0 = overlap_cnt;
    d_xact(1'b1, 32'h20, 32'h11223344, 4'b0101, rd, er, lat);
    n_checks++;
    if (lat !== 2 || rd !== 32'h0 || er !== SUCCESS)
      $display("FAIL wr_rsp got lat=%0d data=%h err=%0d want 2/0/0", lat, rd, er);
    else n_pass++;
    d_xact(1'b0, 32'h20, 32'h0, 4'b0000, rd, er, lat);
    n_checks++;
    if (lat !== 2 || rd !== 32'hAA22CC44 || er !== SUCCESS)
      $display("FAIL wr_readback got lat=%0d data=%h err=%0d want 2/aa22cc44/0",
               lat, rd, er);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (overlap_cnt !== ov0)
      $display("FAIL wr_overlap got %0d want %0d", overlap_cnt, ov0);
    else n_pass++;
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic [1:0]  er;
    int lat;
    d_xact(1'b0, 32'h2, 32'h0, 4'b0000, rd, er, lat);
    n_checks++;
    if (lat !== 2 || rd !== 32'h0 || er !== ALIGN)
      $display("FAIL err_align got lat=%0d data=%h err=%0d want 2/0/%0d",
               lat, rd, er, ALIGN);
    else n_pass++;
    d_xact(1'b0, 32'(4 * MEMW), 32'h0, 4'b0000, rd, er, lat);
    n_checks++;
    if (lat !== 2 || rd !== 32'h0 || er !== OOB)
      $display("FAIL err_oob_rd got lat=%0d data=%h err=%0d want 2/0/%0d",
               lat, rd, er, OOB);
    else n_pass++;
    d_xact(1'b1, 32'(4 * MEMW + 4), 32'h12345678, 4'b1111, rd, er, lat);
    n_checks++;
    if (lat !== 2 || rd !== 32'h0 || er !== OOB)
      $display("FAIL err_oob_wr got lat=%0d data=%h err=%0d want 2/0/%0d",
               lat, rd, er, OOB);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int gown[$], gcyc[$], rown[$], rcyc[$];
    logic [31:0] rdat[$];
    logic [31:0] want;
    int both;
    both = 0;
    apply_reset();
    @(posedge clk); #1;
    i_req_valid = 1'b1;
    i_req_addr = 32'h10;
    d_req_valid = 1'b1;
    d_req_we = 1'b0;
    d_req_addr = 32'h20;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (i_req_ready && d_req_ready) both++;
      if (d_req_ready) begin
        gown.push_back(1);
        gcyc.push_back(c);
      end else if (i_req_ready) begin
        gown.push_back(0);
        gcyc.push_back(c);
      end
      if (i_rsp_valid) begin
        rown.push_back(0);
        rcyc.push_back(c);
        rdat.push_back(i_rsp_data);
      end
      if (d_rsp_valid) begin
        rown.push_back(1);
        rcyc.push_back(c);
        rdat.push_back(d_rsp_data);
      end
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (both !== 0) $display("FAIL rr_both_ready got %0d want 0", both);
    else n_pass++;
    n_checks++;
    if (gown.size() !== 8 || rown.size() !== 7)
      $display("FAIL rr_counts got %0d/%0d want 8/7", gown.size(), rown.size());
    else n_pass++;
    for (int k = 0; k < gown.size(); k++) begin
      n_checks++;
      if (gown[k] !== int'(k % 2 == 0) || gcyc[k] !== 2 * k)
        $display("FAIL rr_grant%0d got owner=%0d cyc=%0d want %0d/%0d",
                 k, gown[k], gcyc[k], int'(k % 2 == 0), 2 * k);
      else n_pass++;
    end
    for (int k = 0; k < rown.size(); k++) begin
      want = (k % 2 == 0) ? 32'hAA22CC44 : 32'hDEADBEEF;
      n_checks++;
      if (rown[k] !== int'(k % 2 == 0) || rcyc[k] !== 2 * k + 2 ||
          rdat[k] !== want)
        $display("FAIL rr_rsp%0d got owner=%0d cyc=%0d data=%h want %0d/%0d/%h",
                 k, rown[k], rcyc[k], rdat[k], int'(k % 2 == 0), 2 * k + 2, want);
      else n_pass++;
    end
  endtask

  task automatic test_clk_enable();
    int cnt0, bad;
    bad = 0;
    @(posedge clk); #1;
    i_req_valid = 1'b1;
    i_req_addr = 32'h14;
    @(negedge clk);
    n_checks++;
    if (i_req_ready !== 1'b1) $display("FAIL ce_accept got %b want 1", i_req_ready);
    else n_pass++;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    clk_enable = 1'b0;
    d_req_valid = 1'b1;
    d_req_we = 1'b0;
    d_req_addr = 32'h20;
    cnt0 = i_rsp_cnt;
    repeat (5) begin
      @(negedge clk);
      if (i_req_ready || d_req_ready || i_rsp_valid || d_rsp_valid ||
          m_r_en || m_w_en || m_clk_enable) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL ce_frozen got %0d active cycles want 0", bad);
    else n_pass++;
    @(posedge clk); #1;
    clk_enable = 1'b1;
    d_req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_r_en !== 1'b1 || m_r_addr !== 32'h14)
      $display("FAIL ce_resume_issue got en=%b addr=%h want 1/00000014",
               m_r_en, m_r_addr);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (i_rsp_valid !== 1'b1 || i_rsp_data !== 32'h5555AAAA || i_rsp_err !== SUCCESS)
      $display("FAIL ce_resume_rsp got v=%b data=%h err=%0d want 1/5555aaaa/0",
               i_rsp_valid, i_rsp_data, i_rsp_err);
    else n_pass++;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    n_checks++;
    if (i_rsp_cnt - cnt0 !== 1)
      $display("FAIL ce_once got %0d responses want 1", i_rsp_cnt - cnt0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cnt0;
    @(posedge clk); #1;
    d_req_valid = 1'b1;
    d_req_we = 1'b0;
    d_req_addr = 32'h10;
    @(negedge clk);
    @(posedge clk); #1 d_req_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    cnt0 = d_rsp_cnt + i_rsp_cnt;
    @(negedge clk);
    n_checks++;
    if ({i_rsp_valid, d_rsp_valid} !== 2'b00)
      $display("FAIL rm_rsp_in_reset got %b want 00", {i_rsp_valid, d_rsp_valid});
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    n_checks++;
    if (d_rsp_cnt + i_rsp_cnt !== cnt0)
      $display("FAIL rm_no_dup got %0d responses want %0d",
               d_rsp_cnt + i_rsp_cnt, cnt0);
    else n_pass++;
    i_req_valid = 1'b1;
    i_req_addr = 32'h10;
    d_req_valid = 1'b1;
    d_req_addr = 32'h20;
    @(negedge clk);
    n_checks++;
    if ({i_req_ready, d_req_ready} !== 2'b01)
      $display("FAIL rm_idle_grant got %b want 01", {i_req_ready, d_req_ready});
    else n_pass++;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_random();
    bit pend, p_d, p_we, last_d, ei, ed, r, e, ia, da;
    int age;
    logic [31:0] p_addr, p_wdata, e_data, got_d;
    logic [3:0]  p_wstrb;
    logic [1:0]  e_err, got_e;
    pend = 0; p_d = 0; p_we = 0; last_d = 0; age = 0;
    p_addr = '0; p_wdata = '0; p_wstrb = '0; e_data = '0; e_err = SUCCESS;
    apply_reset();
    for (int k = 0; k < MEMW; k++) gold[k] = mem[k];
    ia = 1; da = 1;
    for (int c = 0; c < 600; c++) begin
      if (!i_req_valid || ia) begin
        i_req_valid = ($urandom % 3) != 0;
        i_req_addr = rnd_addr();
      end
      if (!d_req_valid || da) begin
        d_req_valid = ($urandom % 3) != 0;
        d_req_we = 1'($urandom % 2);
        d_req_addr = rnd_addr();
        d_req_wdata = $urandom;
        d_req_wstrb = 4'($urandom);
      end
      clk_enable = ($urandom % 8) != 0;
      @(negedge clk);
      ed = clk_enable && (!pend || age == 2) && d_req_valid &&
           (!i_req_valid || !last_d);
      ei = clk_enable && (!pend || age == 2) && i_req_valid && !ed;
      n_checks++;
      if ({i_req_ready, d_req_ready} !== {ei, ed})
        $display("FAIL rnd_ready c=%0d got %b want %b",
                 c, {i_req_ready, d_req_ready}, {ei, ed});
      else n_pass++;
      r = clk_enable && pend && age == 2;
      n_checks++;
      if ({i_rsp_valid, d_rsp_valid} !== {r && !p_d, r && p_d})
        $display("FAIL rnd_rsp_valid c=%0d got %b want %b",
                 c, {i_rsp_valid, d_rsp_valid}, {r && !p_d, r && p_d});
      else n_pass++;
      if (r) begin
        got_d = p_d ? d_rsp_data : i_rsp_data;
        got_e = p_d ? d_rsp_err : i_rsp_err;
        n_checks++;
        if (got_d !== e_data || got_e !== e_err)
          $display("FAIL rnd_rsp c=%0d addr=%h got %h/%0d want %h/%0d",
                   c, p_addr, got_d, got_e, e_data, e_err);
        else n_pass++;
      end
      e = clk_enable && pend && age == 1;
      n_checks++;
      if ({m_r_en, m_w_en} !== {e && !p_we, e && p_we})
        $display("FAIL rnd_mem_en c=%0d got %b want %b",
                 c, {m_r_en, m_w_en}, {e && !p_we, e && p_we});
      else n_pass++;
      if (e) begin
        n_checks++;
        if ((p_we ? m_w_addr : m_r_addr) !== p_addr ||
            (p_we && {m_w_data, m_w_strb} !== {p_wdata, p_wstrb}))
          $display("FAIL rnd_mem_bus c=%0d got %h %h %h want %h %h %h",
                   c, p_we ? m_w_addr : m_r_addr, m_w_data, m_w_strb,
                   p_addr, p_wdata, p_wstrb);
        else n_pass++;
      end
      ia = i_req_valid && i_req_ready;
      da = d_req_valid && d_req_ready;
      @(posedge clk);
      if (clk_enable) begin
        if (pend) begin
          age++;
          if (age > 2) pend = 0;
        end
        if (ei || ed) begin
          pend = 1;
          age = 1;
          p_d = ed;
          last_d = ed;
          p_we = ed && d_req_we;
          p_addr = ed ? d_req_addr : i_req_addr;
          p_wdata = d_req_wdata;
          p_wstrb = d_req_wstrb;
          e_err = status_of(p_addr);
          e_data = '0;
          if (e_err == SUCCESS) begin
            if (p_we) begin
              for (int b = 0; b < 4; b++)
                if (p_wstrb[b]) gold[p_addr[7:2]][8*b +: 8] = p_wdata[8*b +: 8];
            end else begin
              e_data = gold[p_addr[7:2]];
            end
          end
        end
      end
      #1;
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    clk_enable = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_errors();
    test_round_robin();
    test_clk_enable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
